// File: rtl/instruction_fetch_stage.sv
// IF stage plus IF/ID pipeline register: owns the PC, drives instruction memory,
// applies redirect/stall/idle priority and counts accepted fetches.
module instruction_fetch_stage #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned PC_STEP   = 4,
    parameter logic [31:0] NOP_WORD  = 32'hF000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_data,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 fetch_enable,
    output logic [31:0]          instruction,
    output logic [PC_WIDTH-1:0]  instr_pc,
    output logic                 instr_valid,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam logic [PC_WIDTH-1:0]  PC_RST  = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0]  PC_INC  = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [PC_WIDTH-1:0]  r_pc_p0;
    logic [31:0]          r_instr_p1;
    logic [PC_WIDTH-1:0]  r_instr_pc_p1;
    logic                 r_vld_p1;
    logic [CNT_WIDTH-1:0] r_fetch_count;

    logic [PC_WIDTH-1:0]  w_pc_nxt;
    logic [31:0]          w_instr_nxt;
    logic [PC_WIDTH-1:0]  w_instr_pc_nxt;
    logic                 w_vld_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // Memory address comes straight from the PC register, never from branch_target.
    assign imem_addr = r_pc_p0;

    always_comb begin
        w_pc_nxt       = r_pc_p0;
        w_instr_nxt    = r_instr_p1;
        w_instr_pc_nxt = r_instr_pc_p1;
        w_vld_nxt      = r_vld_p1;
        w_cnt_nxt      = r_fetch_count;
        if (branch_taken) begin
            w_pc_nxt       = branch_target;
            w_instr_nxt    = NOP_WORD;
            w_instr_pc_nxt = '0;
            w_vld_nxt      = 1'b0;
        end else if (stall) begin
            w_pc_nxt = r_pc_p0;
        end else if (!fetch_enable) begin
            w_instr_nxt    = NOP_WORD;
            w_instr_pc_nxt = r_pc_p0;
            w_vld_nxt      = 1'b0;
        end else begin
            w_pc_nxt       = r_pc_p0 + PC_INC;
            w_instr_nxt    = imem_data;
            w_instr_pc_nxt = r_pc_p0;
            w_vld_nxt      = 1'b1;
            w_cnt_nxt      = sat_inc(r_fetch_count);
        end
    end

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_p0       <= PC_RST;
            r_instr_p1    <= NOP_WORD;
            r_instr_pc_p1 <= '0;
            r_vld_p1      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc_p0       <= w_pc_nxt;
            r_instr_p1    <= w_instr_nxt;
            r_instr_pc_p1 <= w_instr_pc_nxt;
            r_vld_p1      <= w_vld_nxt;
            r_fetch_count <= w_cnt_nxt;
        end
    end

    assign instruction = r_instr_p1;
    assign instr_pc    = r_instr_pc_p1;
    assign instr_valid = r_vld_p1;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a cycle model predicts every
// IF/ID, PC and counter value; observed values are queued and compared per scenario.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_enable;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [15:0] fetch_count;

    localparam logic [31:0] NOP = 32'hF000_0000;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] ipc;
        logic        v;
        logic [31:0] addr;
        logic [15:0] cnt;
    } snap_t;

    snap_t q_exp[$];
    snap_t q_obs[$];

    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic [31:0] m_w;
    logic [31:0] m_ipc;
    logic        m_v;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'hA800_0000 + imem_addr;

    instruction_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_enable (fetch_enable),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .fetch_count  (fetch_count)
    );

    // Drive one cycle, predict its outcome, capture what the DUT shows after the edge.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic f);
        reset = r; stall = s; branch_taken = b; branch_target = t; fetch_enable = f;
        if (r) begin
            m_pc = 32'h0; m_cnt = 16'h0; m_w = NOP; m_ipc = 32'h0; m_v = 1'b0;
        end else if (b) begin
            m_w = NOP; m_ipc = 32'h0; m_v = 1'b0; m_pc = t;
        end else if (s) begin
            m_pc = m_pc;
        end else if (!f) begin
            m_w = NOP; m_ipc = m_pc; m_v = 1'b0;
        end else begin
            m_w = 32'hA800_0000 + m_pc; m_ipc = m_pc; m_v = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        q_exp.push_back('{m_w, m_ipc, m_v, m_pc, m_cnt});
        @(posedge clk);
        #1;
        q_obs.push_back('{instruction, instr_pc, instr_valid, imem_addr, fetch_count});
    endtask

    task automatic test_reset();
        snap_t e, o;
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 32'h80, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL reset: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
        n_chk++;
        if (imem_addr !== 32'h0 || instruction !== NOP) $display("FAIL reset_const: got addr=%h instr=%h, need 0 and %h", imem_addr, instruction, NOP);
        else n_pass++;
    endtask

    task automatic test_normal();
        snap_t e, o;
        step(1, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL normal: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
        n_chk++;
        if (fetch_count !== 16'd4 || imem_addr !== 32'd16 || instr_pc !== 32'd12)
            $display("FAIL normal_const: got cnt=%0d addr=%h ipc=%h, need 4, 10, c", fetch_count, imem_addr, instr_pc);
        else n_pass++;
    endtask

    task automatic test_stall();
        snap_t e, o;
        step(1, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        n_chk++;
        if (instr_pc !== 32'd8 || imem_addr !== 32'd12 || instruction !== 32'hA800_0008)
            $display("FAIL stall_hold: got ipc=%h addr=%h instr=%h, need 8, c, a8000008", instr_pc, imem_addr, instruction);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL stall: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        snap_t e, o;
        step(0, 0, 1, 32'h20, 1);
        step(0, 0, 1, 32'h100, 1);
        n_chk++;
        if (instruction !== NOP || instr_valid !== 1'b0 || imem_addr !== 32'h100)
            $display("FAIL branch_squash: got instr=%h v=%b addr=%h, need f0000000 0 100", instruction, instr_valid, imem_addr);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL branch: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_branch_stall();
        snap_t e, o;
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 32'h40, 1);
        n_chk++;
        if (imem_addr !== 32'h40 || instr_valid !== 1'b0)
            $display("FAIL branch_stall_const: got addr=%h v=%b, need 40 0", imem_addr, instr_valid);
        else n_pass++;
        step(0, 0, 1, 32'h200, 1);
        step(0, 0, 1, 32'h300, 1);
        step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL branch_stall_b2b: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_idle();
        snap_t e, o;
        step(0, 0, 1, 32'h10, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        n_chk++;
        if (instr_pc !== 32'h10 || instr_valid !== 1'b0 || imem_addr !== 32'h10)
            $display("FAIL idle_const: got ipc=%h v=%b addr=%h, need 10 0 10", instr_pc, instr_valid, imem_addr);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL idle: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_stall();
        snap_t e, o;
        step(0, 0, 1, 32'h30, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        n_chk++;
        if (imem_addr !== 32'h0 || fetch_count !== 16'h0 || instruction !== NOP || instr_valid !== 1'b0)
            $display("FAIL reset_stall_const: got addr=%h cnt=%h instr=%h v=%b, need 0 0 f0000000 0", imem_addr, fetch_count, instruction, instr_valid);
        else n_pass++;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL reset_stall: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        snap_t e, o;
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        n_chk++;
        if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1)
            $display("FAIL wrap_const: got addr=%h ipc=%h v=%b, need 0 fffffffc 1", imem_addr, instr_pc, instr_valid);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) $display("FAIL wrap: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        snap_t e, o;
        int bad = 0;
        step(1, 0, 0, 0, 1);
        repeat (65537) step(0, 0, 0, 0, 1);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); o = q_obs.pop_front(); n_chk++;
            if (o !== e) begin
                if (bad < 5) $display("FAIL saturation: got w=%h pc=%h v=%b addr=%h cnt=%h, need w=%h pc=%h v=%b addr=%h cnt=%h",
                    o.w, o.ipc, o.v, o.addr, o.cnt, e.w, e.ipc, e.v, e.addr, e.cnt);
                bad++;
            end else n_pass++;
        end
        n_chk++;
        if (fetch_count !== 16'hFFFF) $display("FAIL sat_const: got cnt=%h, need ffff", fetch_count);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; fetch_enable = 1'b1;
        m_pc = 32'h0; m_cnt = 16'h0; m_w = NOP; m_ipc = 32'h0; m_v = 1'b0;
        test_reset();
        test_normal();
        test_stall();
        test_branch();
        test_branch_stall();
        test_idle();
        test_reset_mid_stall();
        test_wrap();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
